voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphony scheduler between the PS/2 keyboard decoder and the modulator synth.
- Compares a snapshot of the 32-bit pressed-key array against the previous snapshot.
- Assigns newly pressed keys to a fixed pool of synth voices and releases voices whose key was let go.
- Drives per-voice key index, gate and note-on trigger into the synth datapath.
- Scan is requested once per audio sample tick, derived from the DAC LR clock.

Parameters:
NUM_KEYS, 32, width of key array; keys indexed 0..NUM_KEYS-1
NUM_VOICES, 4, size of voice pool
KEY_W, 5, key index width, $clog2(NUM_KEYS)
AGE_W, 4, per-voice age counter width, saturating

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  reset; synchronous, active-high
i_key  in  NUM_KEYS  pressed-key array from keyboard decoder, level
i_scan_start  in  1  one-cycle scan request
o_busy  out  1  high from the cycle after an accepted i_scan_start until DONE is left
o_done  out  1  one-cycle pulse at scan completion
o_voice_key  out  NUM_VOICES*KEY_W  key index per voice; voice v at bits [v*KEY_W +: KEY_W]
o_voice_gate  out  NUM_VOICES  voice sounding
o_voice_trig  out  NUM_VOICES  one-cycle note-on pulse, coincident with o_done
o_drop  out  1  one-cycle pulse with o_done if any press was dropped; tied 0 when stealing is enabled

Behaviour:
- Reset values:
  - all outputs 0
  - key_prev, key_snap, ages, trig_acc, drop_acc cleared
  - FSM in IDLE
  - Reset mid-scan aborts immediately; because key_prev is cleared, keys still held retrigger on the next scan.
- IDLE:
  - i_scan_start=1 → latch key_snap<=i_key, clear trig_acc/drop_acc, idx<=0, go to SCAN.
  - i_scan_start while not IDLE is ignored, with no queuing.
- SCAN: one key per cycle, idx = 0..NUM_KEYS-1 ascending.
  - Release (key_prev[idx]=1, key_snap[idx]=0):
    - every voice with gate=1 and key==idx gets gate<=0; key field is kept.
    - no match (note was stolen earlier): no action.
  - Press (key_prev[idx]=0, key_snap[idx]=1):
    - target = lowest-index voice with gate=0.
    - If none, target = voice with largest age; ties go to the lowest index.
    - On target: key<=idx, gate<=1, age<=0, trig_acc[target]<=1.
    - Every other voice with gate=1: age saturating +1 (max 2^AGE_W-1).
  - Unchanged key: no action.
  - idx==NUM_KEYS-1 → go to DONE.
- DONE (1 cycle):
  - o_done=1, o_voice_trig=trig_acc, o_drop=|drop_acc.
  - key_prev<=key_snap; go to IDLE.
- Latency: i_scan_start to o_done = NUM_KEYS+1 cycles (33 at default).
- Gate/key updates are visible the cycle after the key's SCAN cycle; trig is deferred to DONE.
- A voice assigned twice in one scan (steal, then re-steal): single trig, latest key wins.
- i_key changes during SCAN are ignored; the snapshot rules.

Optional Feature:
VOICE_ALLOC_STEAL_EN
- Defined: voice stealing of the oldest voice as above; o_drop constant 0.
- Undefined: a press with no free voice is dropped, drop_acc<=1, and no voice or age changes.
  - The dropped key stays in key_prev, so it is not retried until released and re-pressed.

Decomposition:
- Package voice_pkg:
  - FSM state enum (S_IDLE, S_SCAN, S_DONE)
  - NUM_KEYS/NUM_VOICES/KEY_W/AGE_W defaults
  - typedef voice_t {key, gate, age}
- Sub-module voice_pick: combinational selector; inputs gates and ages, outputs free_found, free_idx and oldest_idx.

Test Plan:
- Reset, then scan with i_key=0 → o_done exactly 33 cycles after i_scan_start; all gates 0, trig 0.
- i_key=32'h0000_0009, scan → voice0 key=0, voice1 key=3, gates 4'b0011, trig 4'b0011 on o_done.
- Next scan with i_key=32'h0000_0008 → voice0 gate 0, voice1 stays key=3 gate 1, trig 0.
- Press keys 1,2,4,5 over four scans, then press key 6 with STEAL_EN → voice holding key 1 (oldest) becomes key 6 with trig on that voice only. Without STEAL_EN → no change, o_drop=1.
- Assert i_rst 10 cycles into a scan with keys held → outputs 0 next cycle; the following scan retriggers all held keys.
- i_scan_start pulsed again while o_busy → ignored; exactly one o_done.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared types and defaults for the polyphony voice allocator.
// FSM states, pool sizing defaults, per-voice record and age helper.
package voice_pkg;

    localparam int NUM_KEYS_DEF   = 32;
    localparam int NUM_VOICES_DEF = 4;
    localparam int KEY_W_DEF      = 5;
    localparam int AGE_W_DEF      = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [KEY_W_DEF-1:0] key;
        logic                 gate;
        logic [AGE_W_DEF-1:0] age;
    } voice_t;

    // Saturating age increment; a stuck-at-max voice stays the steal candidate.
    function automatic logic [AGE_W_DEF-1:0] age_inc(
        input logic [AGE_W_DEF-1:0] a
    );
        return (&a) ? a : a + AGE_W_DEF'(1);
    endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational voice selector: lowest free voice and oldest voice.
// Ports: gates/ages in (ages flat, AGE_W per voice); free_found, free_idx, oldest_idx out.
module voice_pick
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0]       gates,
    input  logic [NUM_VOICES*AGE_W-1:0] ages,
    output logic                        free_found,
    output logic [IDX_W-1:0]            free_idx,
    output logic [IDX_W-1:0]            oldest_idx
);

    logic [AGE_W-1:0] best_age;

    // Descending walk so the lowest free index is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!gates[v]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
        end
    end

    // Strict compare keeps ties on the lowest index.
    always_comb begin
        best_age   = ages[0 +: AGE_W];
        oldest_idx = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (ages[v*AGE_W +: AGE_W] > best_age) begin
                best_age   = ages[v*AGE_W +: AGE_W];
                oldest_idx = IDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: diffs key snapshots, assigns/releases synth voices.
// Ports: i_clk, i_rst (sync, high), i_key, i_scan_start in;
// o_busy, o_done, o_voice_key, o_voice_gate, o_voice_trig, o_drop out.
// Build option: VOICE_ALLOC_STEAL_EN steals the oldest voice when the pool is full;
// otherwise such presses are dropped and flagged on o_drop.
// KEY_W and AGE_W must match the widths carried in voice_t.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int KEY_W      = KEY_W_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_KEYS-1:0]         i_key,
    input  logic                        i_scan_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
    output logic [NUM_VOICES-1:0]       o_voice_gate,
    output logic [NUM_VOICES-1:0]       o_voice_trig,
    output logic                        o_drop
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t                  state;
    logic [NUM_KEYS-1:0]     key_prev;
    logic [NUM_KEYS-1:0]     key_snap;
    logic [KEY_W-1:0]        idx;
    voice_t                  voice_q [NUM_VOICES];
    logic [NUM_VOICES-1:0]   trig_acc;
    logic                    drop_acc;

    logic [NUM_VOICES-1:0]       gates;
    logic [NUM_VOICES*AGE_W-1:0] ages;
    logic                        free_found;
    logic [VW-1:0]               free_idx;
    logic [VW-1:0]               oldest_idx;

    logic                  press;
    logic                  release_k;
    logic                  assign_ok;
    logic                  drop_now;
    logic                  last;
    logic [VW-1:0]         target;
    logic [NUM_VOICES-1:0] trig_nxt;
    logic                  drop_nxt;

    always_comb begin
        gates       = '0;
        ages        = '0;
        o_voice_key = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            gates[v]                     = voice_q[v].gate;
            ages[v*AGE_W +: AGE_W]       = voice_q[v].age;
            o_voice_key[v*KEY_W +: KEY_W] = voice_q[v].key;
        end
    end

    assign o_voice_gate = gates;
    assign o_busy       = (state != S_IDLE);

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (VW)
    ) u_pick (
        .gates      (gates),
        .ages       (ages),
        .free_found (free_found),
        .free_idx   (free_idx),
        .oldest_idx (oldest_idx)
    );

    always_comb begin
        press     = (state == S_SCAN) && key_snap[idx] && !key_prev[idx];
        release_k = (state == S_SCAN) && !key_snap[idx] && key_prev[idx];
        target    = free_found ? free_idx : oldest_idx;
`ifdef VOICE_ALLOC_STEAL_EN
        assign_ok = press;
        drop_now  = 1'b0;
`else
        assign_ok = press && free_found;
        drop_now  = press && !free_found;
`endif
        trig_nxt  = trig_acc;
        if (assign_ok) begin
            trig_nxt = trig_acc | (NUM_VOICES'(1) << target);
        end
        drop_nxt  = drop_acc | drop_now;
        last      = (idx == KEY_W'(NUM_KEYS - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            key_prev     <= '0;
            key_snap     <= '0;
            idx          <= '0;
            trig_acc     <= '0;
            drop_acc     <= 1'b0;
            o_done       <= 1'b0;
            o_voice_trig <= '0;
            o_drop       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_q[v] <= '0;
            end
        end else begin
            o_done       <= 1'b0;
            o_voice_trig <= '0;
            o_drop       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_scan_start) begin
                        key_snap <= i_key;
                        trig_acc <= '0;
                        drop_acc <= 1'b0;
                        idx      <= '0;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        // Key field is kept on release; only the gate drops.
                        if (release_k && voice_q[v].gate &&
                            voice_q[v].key == idx) begin
                            voice_q[v].gate <= 1'b0;
                        end
                        if (assign_ok) begin
                            if (VW'(v) == target) begin
                                voice_q[v].key  <= idx;
                                voice_q[v].gate <= 1'b1;
                                voice_q[v].age  <= '0;
                            end else if (voice_q[v].gate) begin
                                voice_q[v].age <= age_inc(voice_q[v].age);
                            end
                        end
                    end
                    trig_acc <= trig_nxt;
                    drop_acc <= drop_nxt;
                    if (last) begin
                        state        <= S_DONE;
                        o_done       <= 1'b1;
                        o_voice_trig <= trig_nxt;
                        o_drop       <= drop_nxt;
                    end else begin
                        idx <= idx + KEY_W'(1);
                    end
                end
                S_DONE: begin
                    // Dropped presses land in key_prev too and are not retried.
                    key_prev <= key_snap;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: scan latency, assign/release,
// full-pool handling (steal or drop per build), reset abort, start while busy.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] key = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [19:0] vkey;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic        drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    voice_allocator dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key        (key),
        .i_scan_start (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_voice_key  (vkey),
        .o_voice_gate (gate),
        .o_voice_trig (trig),
        .o_drop       (drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] kv(input int k3, input int k2,
                                       input int k1, input int k0);
        return {5'(k3), 5'(k2), 5'(k1), 5'(k0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input string tag, input logic [31:0] keys,
                        input logic [3:0] eg, input logic [19:0] ek,
                        input logic [3:0] et, input logic ed);
        int n;
        key   = keys;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n + 1), 32'd33);
        chk({tag, "_gate"}, 32'(gate), 32'(eg));
        chk({tag, "_key"}, 32'(vkey), 32'(ek));
        chk({tag, "_trig"}, 32'(trig), 32'(et));
        chk({tag, "_drop"}, 32'(drop), 32'(ed));
        step();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        step();
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_key", 32'(vkey), 32'd0);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        rst = 1'b0;
        step();

        scan("empty", 32'h0, 4'b0000, kv(0, 0, 0, 0), 4'b0000, 1'b0);
        scan("k0k3", 32'h9, 4'b0011, kv(0, 0, 3, 0), 4'b0011, 1'b0);
        scan("rel0", 32'h8, 4'b0010, kv(0, 0, 3, 0), 4'b0000, 1'b0);
        scan("k1", 32'hA, 4'b0011, kv(0, 0, 3, 1), 4'b0001, 1'b0);
        scan("k2", 32'hE, 4'b0111, kv(0, 2, 3, 1), 4'b0100, 1'b0);
        scan("k4", 32'h1E, 4'b1111, kv(4, 2, 3, 1), 4'b1000, 1'b0);
`ifdef VOICE_ALLOC_STEAL_EN
        scan("k5", 32'h3E, 4'b1111, kv(4, 2, 5, 1), 4'b0010, 1'b0);
        scan("k6", 32'h7E, 4'b1111, kv(4, 2, 5, 6), 4'b0001, 1'b0);
        scan("k78", 32'h1FE, 4'b1111, kv(8, 7, 5, 6), 4'b1100, 1'b0);
`else
        scan("k5", 32'h3E, 4'b1111, kv(4, 2, 3, 1), 4'b0000, 1'b1);
        scan("k6", 32'h7E, 4'b1111, kv(4, 2, 3, 1), 4'b0000, 1'b1);
        scan("k78", 32'h1FE, 4'b1111, kv(4, 2, 3, 1), 4'b0000, 1'b1);
`endif

        key   = 32'h1FE;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_key", 32'(vkey), 32'd0);
        chk("abort_gate", 32'(gate), 32'd0);
        chk("abort_trig", 32'(trig), 32'd0);
        chk("abort_drop", 32'(drop), 32'd0);
        rst = 1'b0;
        step();

`ifdef VOICE_ALLOC_STEAL_EN
        scan("retrig", 32'h1FE, 4'b1111, kv(8, 7, 6, 5), 4'b1111, 1'b0);
`else
        scan("retrig", 32'h1FE, 4'b1111, kv(4, 3, 2, 1), 4'b1111, 1'b1);
`endif

        ndone = 0;
        start = 1'b1;
        step();
        for (int i = 0; i < 80; i++) begin
            start = (i == 5);
            step();
            if (i == 5) chk("dbl_busy", 32'(busy), 32'd1);
            if (done) begin
                ndone++;
                chk("dbl_trig", 32'(trig), 32'd0);
                chk("dbl_drop", 32'(drop), 32'd0);
            end
        end
        start = 1'b0;
        chk("dbl_ndone", 32'(ndone), 32'd1);
        chk("dbl_gate", 32'(gate), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
